// File: rtl/stack_seq.sv
// stack_seq: PUSH/POP sequencer for the 16-bit CPU.
// Owns the stack pointer and fill count, drives the data RAM, flags
// overflow/underflow/protocol errors and returns popped words with a done pulse.
module stack_seq #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] STACK_TOP = 16'h00FF,
  parameter int                DEPTH     = 64,
  parameter int                RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_push,
  input  logic              start_pop,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W-1:0] sp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic              underflow,
  output logic              proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_WR, S_POP_RD, S_POP_WAIT, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic [LW-1:0] lat_cnt;
  logic          lat_last;
  logic          set_ovf, set_udf, set_proto, do_flush;

  assign lat_last = (lat_cnt == LW'(RD_LAT - 1));
  assign busy     = (state != S_IDLE);

  // Next-state decode and one-cycle event strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_nx  = state;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    set_proto = 1'b0;
    do_flush  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_push && start_pop) begin
          set_proto = 1'b1;
          state_nx  = S_ERR;
        end else if (start_push) begin
          if (count < DEPTH_C) state_nx = S_PUSH_WR;
          else begin
            set_ovf  = 1'b1;
            state_nx = S_ERR;
          end
        end else if (start_pop) begin
          if (count != '0) state_nx = S_POP_RD;
          else begin
            set_udf  = 1'b1;
            state_nx = S_ERR;
          end
        end else if (flush) begin
          do_flush = 1'b1;
        end
      end
      S_PUSH_WR:  state_nx = S_DONE;
      S_POP_RD:   state_nx = S_POP_WAIT;
      S_POP_WAIT: if (lat_last) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      S_ERR:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Stack pointer and fill count; moved only by a completed RAM access or a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp    <= STACK_TOP;
      count <= '0;
    end else if (do_flush) begin
      sp    <= STACK_TOP;
      count <= '0;
    end else if (state == S_PUSH_WR) begin
      sp    <= sp - ADDR_W'(1);
      count <= count + CW'(1);
    end else if (state == S_POP_RD) begin
      sp    <= sp + ADDR_W'(1);
      count <= count - CW'(1);
    end
  end

  // Read-latency counter for POP_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    lat_cnt <= '0;
    else if (state == S_POP_WAIT) lat_cnt <= lat_cnt + LW'(1);
    else                          lat_cnt <= '0;
  end

  // Data capture: din on the push request, RAM data on the last wait cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_wdata <= '0;
      pop_data  <= '0;
    end else begin
      if (state == S_IDLE && start_push)  ram_wdata <= din;
      if (state == S_POP_WAIT && lat_last) pop_data <= ram_rdata;
    end
  end

  // Registered RAM strobes, address and completion pulse, decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ram_we   <= (state_nx == S_PUSH_WR);
      ram_re   <= (state_nx == S_POP_RD);
      if (state_nx == S_PUSH_WR)     ram_addr <= sp;
      else if (state_nx == S_POP_RD) ram_addr <= sp + ADDR_W'(1);
      else                           ram_addr <= '0;
      done     <= (state_nx == S_DONE) || (state_nx == S_ERR);
      err      <= (state_nx == S_ERR);
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      overflow  <= set_ovf   | (overflow  & ~clr_err);
      underflow <= set_udf   | (underflow & ~clr_err);
      proto_err <= set_proto | (proto_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed testbench for stack_seq with a behavioural RAM (read latency 1).
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_push = 1'b0, start_pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] ram_rdata;
  logic [15:0] ram_addr, ram_wdata, pop_data, sp;
  logic        ram_we, ram_re, busy, done, err, overflow, underflow, proto_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:255];
  logic [15:0] rd_q = '0;

  always #5 clk = ~clk;

  // RAM model: synchronous write, data valid one cycle after ram_re.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_re) rd_q <= mem[ram_addr[7:0]];
  end
  assign ram_rdata = rd_q;

  stack_seq dut (
    .clk(clk), .reset(reset), .start_push(start_push), .start_pop(start_pop),
    .flush(flush), .clr_err(clr_err), .din(din), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .pop_data(pop_data), .sp(sp), .busy(busy), .done(done), .err(err),
    .overflow(overflow), .underflow(underflow), .proto_err(proto_err)
  );

  // Issue a push and wait (bounded) for done; reports done seen and err.
  task automatic push_op(input logic [15:0] d, output logic got, output logic e);
    @(negedge clk); start_push = 1'b1; din = d;
    @(negedge clk); start_push = 1'b0;
    got = 1'b0; e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin got = 1'b1; e = err; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Issue a pop and wait (bounded) for done; returns pop_data at done.
  task automatic pop_op(output logic [15:0] d, output logic got, output logic e);
    @(negedge clk); start_pop = 1'b1;
    @(negedge clk); start_pop = 1'b0;
    got = 1'b0; e = 1'b0; d = '0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin got = 1'b1; e = err; d = pop_data; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sp !== 16'h00FF) begin failures++; $display("FAIL reset_sp got=%h exp=00ff", sp); end
    checks++; if ({busy, done, err, ram_we, ram_re} !== 5'b0) begin failures++;
      $display("FAIL reset_ctl got=%b exp=00000", {busy, done, err, ram_we, ram_re}); end
    checks++; if ({overflow, underflow, proto_err} !== 3'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {overflow, underflow, proto_err}); end
    checks++; if (pop_data !== 16'h0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0) begin failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", pop_data, ram_addr, ram_wdata); end
  endtask

  task automatic test_push;
    @(negedge clk); start_push = 1'b1; din = 16'h1234;
    @(negedge clk); start_push = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h00FF || ram_wdata !== 16'h1234 || busy !== 1'b1) begin
      failures++; $display("FAIL push_cyc1 got we=%b addr=%h wdata=%h busy=%b exp 1/00ff/1234/1",
                           ram_we, ram_addr, ram_wdata, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || err !== 1'b0 || sp !== 16'h00FE || ram_we !== 1'b0) begin
      failures++; $display("FAIL push_cyc2 got done=%b err=%b sp=%h we=%b exp 1/0/00fe/0",
                           done, err, sp, ram_we); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL push_idle got done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_pop;
    @(negedge clk); start_pop = 1'b1;
    @(negedge clk); start_pop = 1'b0;
    checks++; if (ram_re !== 1'b1 || ram_addr !== 16'h00FF || ram_we !== 1'b0) begin failures++;
      $display("FAIL pop_cyc1 got re=%b addr=%h we=%b exp 1/00ff/0", ram_re, ram_addr, ram_we); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || ram_re !== 1'b0) begin failures++;
      $display("FAIL pop_cyc2 got done=%b re=%b exp 0/0", done, ram_re); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || err !== 1'b0 || pop_data !== 16'h1234 || sp !== 16'h00FF) begin
      failures++; $display("FAIL pop_cyc3 got done=%b err=%b data=%h sp=%h exp 1/0/1234/00ff",
                           done, err, pop_data, sp); end
    @(negedge clk);
  endtask

  task automatic test_underflow;
    @(negedge clk); start_pop = 1'b1;
    @(negedge clk); start_pop = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b1 || underflow !== 1'b1 || ram_re !== 1'b0 || sp !== 16'h00FF) begin
      failures++; $display("FAIL udf_cyc1 got done=%b err=%b udf=%b re=%b sp=%h exp 1/1/1/0/00ff",
                           done, err, underflow, ram_re, sp); end
    checks++; if (pop_data !== 16'h1234) begin failures++;
      $display("FAIL udf_popdata_held got=%h exp=1234", pop_data); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if (underflow !== 1'b0) begin failures++;
      $display("FAIL udf_clr got=%b exp=0", underflow); end
  endtask

  task automatic test_clr_set_same;
    // Pop on empty with clr_err in the same cycle: the set must win.
    @(negedge clk); start_pop = 1'b1; clr_err = 1'b1;
    @(negedge clk); start_pop = 1'b0; clr_err = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++;
      $display("FAIL clr_set_same got=%b exp=1", underflow); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_overflow;
    logic        got, e;
    logic [15:0] d;
    int          bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      push_op(16'hA000 + 16'(i), got, e);
      if (got !== 1'b1 || e !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fill_done got_bad=%0d exp=0", bad); end
    checks++; if (sp !== 16'h00BF) begin failures++; $display("FAIL fill_sp got=%h exp=00bf", sp); end
    @(negedge clk); start_push = 1'b1; din = 16'hDEAD;
    @(negedge clk); start_push = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b1 || overflow !== 1'b1 || ram_we !== 1'b0 || sp !== 16'h00BF) begin
      failures++; $display("FAIL ovf_cyc1 got done=%b err=%b ovf=%b we=%b sp=%h exp 1/1/1/0/00bf",
                           done, err, overflow, ram_we, sp); end
    @(negedge clk);
    bad = 0;
    for (int i = 63; i >= 0; i--) begin
      pop_op(d, got, e);
      if (got !== 1'b1 || e !== 1'b0 || d !== 16'hA000 + 16'(i)) begin
        bad++;
        if (bad == 1) $display("FAIL lifo_pop idx=%0d got=%h exp=%h", i, d, 16'hA000 + 16'(i));
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL lifo_count got_bad=%0d exp=0", bad); end
    checks++; if (sp !== 16'h00FF || overflow !== 1'b1) begin failures++;
      $display("FAIL drain_sp got sp=%h ovf=%b exp 00ff/1", sp, overflow); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_proto;
    @(negedge clk); start_push = 1'b1; start_pop = 1'b1; din = 16'hBEEF;
    @(negedge clk); start_push = 1'b0; start_pop = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b1 || proto_err !== 1'b1 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      failures++; $display("FAIL proto_cyc1 got done=%b err=%b proto=%b we=%b re=%b exp 1/1/1/0/0",
                           done, err, proto_err, ram_we, ram_re); end
    checks++; if (sp !== 16'h00FF || overflow !== 1'b0 || underflow !== 1'b0) begin failures++;
      $display("FAIL proto_side got sp=%h ovf=%b udf=%b exp 00ff/0/0", sp, overflow, underflow); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic got, e;
    // A pop request while the push is busy must be ignored.
    @(negedge clk); start_push = 1'b1; din = 16'h0042;
    @(negedge clk); start_push = 1'b0; start_pop = 1'b1;
    @(negedge clk); start_pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || sp !== 16'h00FE || ram_re !== 1'b0) begin failures++;
      $display("FAIL busy_ignore got busy=%b sp=%h re=%b exp 0/00fe/0", busy, sp, ram_re); end
    push_op(16'h0043, got, e);
    checks++; if (got !== 1'b1 || sp !== 16'h00FD) begin failures++;
      $display("FAIL b2b_push got done=%b sp=%h exp 1/00fd", got, sp); end
    // Flush empties the stack; a following pop underflows.
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (sp !== 16'h00FF || busy !== 1'b0) begin failures++;
      $display("FAIL flush_sp got sp=%h busy=%b exp 00ff/0", sp, busy); end
    @(negedge clk); start_pop = 1'b1;
    @(negedge clk); start_pop = 1'b0;
    checks++; if (err !== 1'b1 || underflow !== 1'b1) begin failures++;
      $display("FAIL flush_empty got err=%b udf=%b exp 1/1", err, underflow); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic got, e;
    push_op(16'h5555, got, e);
    @(negedge clk); start_push = 1'b1; din = 16'h6666;
    @(negedge clk); start_push = 1'b0;
    checks++; if (ram_we !== 1'b1 || sp !== 16'h00FE) begin failures++;
      $display("FAIL mid_pre got we=%b sp=%h exp 1/00fe", ram_we, sp); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0 || sp !== 16'h00FF || busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL mid_reset got we=%b sp=%h busy=%b done=%b exp 0/00ff/0/0", ram_we, sp, busy, done); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (sp !== 16'h00FF || busy !== 1'b0 || ram_wdata !== 16'h0) begin failures++;
      $display("FAIL mid_after got sp=%h busy=%b wdata=%h exp 00ff/0/0000", sp, busy, ram_wdata); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_underflow();
    test_clr_set_same();
    test_overflow();
    test_proto();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout exp=finish before 200000");
    $fatal(1);
  end

endmodule
